// File: rtl/sa_sched_if.sv
// Port bundle for the self-attention phase scheduler: load stream in,
// load strobes, compute issue, output window and clock-gate enables out.
interface sa_sched_if;
  logic       in_valid;
  logic [3:0] T;
  logic       cg_en;
  logic [5:0] ld_addr;
  logic       x_we;
  logic       w_we;
  logic       issue_vld;
  logic [1:0] issue_phase;
  logic [2:0] issue_row;
  logic [2:0] issue_col;
  logic       out_valid;
  logic [2:0] out_row;
  logic [2:0] out_col;
  logic       gclk_en_ld;
  logic       gclk_en_proj;
  logic       gclk_en_score;
  logic       gclk_en_wt;
  logic       gclk_en_out;
  logic       busy;
  logic       ovr_err;

  modport master (
    output in_valid, T, cg_en,
    input  ld_addr, x_we, w_we, issue_vld, issue_phase, issue_row, issue_col,
           out_valid, out_row, out_col, gclk_en_ld, gclk_en_proj, gclk_en_score,
           gclk_en_wt, gclk_en_out, busy, ovr_err
  );

  modport slave (
    input  in_valid, T, cg_en,
    output ld_addr, x_we, w_we, issue_vld, issue_phase, issue_row, issue_col,
           out_valid, out_row, out_col, gclk_en_ld, gclk_en_proj, gclk_en_score,
           gclk_en_wt, gclk_en_out, busy, ovr_err
  );
endinterface

// File: rtl/sa_sched.sv
// Phase scheduler for the SA datapath: counts the 64-beat load, then issues
// PROJ / SCORE / WEIGHT indices with fixed drains, then the output window.
//
// state  | meaning
// IDLE   | waiting for beat 0
// LOAD   | counting input beats 1..63
// PROJ   | issuing projection indices
// D0     | drain after PROJ
// SCORE  | issuing score indices
// D1     | drain after SCORE
// WEIGHT | issuing weighting indices
// D2     | drain after WEIGHT
// OUT    | output window
module sa_sched #(
  parameter int MAC_LAT = 4
) (
  input logic     clk,
  input logic     rst,
  sa_sched_if.slave bus
);

  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(MAC_LAT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_PROJ, S_D0, S_SCORE, S_D1, S_WEIGHT, S_D2, S_OUT
  } state_t;

  state_t state, state_nxt;

  logic [5:0]    beat_q;
  logic [3:0]    teff_q, teff_in, teff_cur;
  logic [DW-1:0] drain_q, drain_d;
  logic [2:0]    teff_m1, col_last;
  logic          ld_act, issue_last, out_last, drain_done;

  logic       issue_vld_q, issue_vld_d;
  logic [1:0] phase_q, phase_d;
  logic [2:0] irow_q, irow_d, icol_q, icol_d;
  logic       ov_q, ov_d;
  logic [2:0] orow_q, orow_d, ocol_q, ocol_d;
  logic       busy_q, ovr_q;

  // Only 1 and 4 tokens are native; anything else runs the full 8-row job.
  assign teff_in    = (bus.T == 4'd1) ? 4'd1 : (bus.T == 4'd4) ? 4'd4 : 4'd8;
  assign teff_cur   = (state == S_IDLE) ? teff_in : teff_q;
  assign teff_m1    = 3'(teff_q - 4'd1);
  assign col_last   = (state == S_SCORE) ? teff_m1 : 3'd7;
  assign issue_last = (irow_q == teff_m1) && (icol_q == col_last);
  assign out_last   = (orow_q == teff_m1) && (ocol_q == 3'd7);
  assign drain_done = (drain_q == '0);
  assign ld_act     = (state == S_IDLE) || (state == S_LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (bus.in_valid) state_nxt = S_LOAD;
      S_LOAD:   if (bus.in_valid && beat_q == 6'd63) state_nxt = S_PROJ;
      S_PROJ:   if (issue_last) state_nxt = S_D0;
      S_D0:     if (drain_done) state_nxt = S_SCORE;
      S_SCORE:  if (issue_last) state_nxt = S_D1;
      S_D1:     if (drain_done) state_nxt = S_WEIGHT;
      S_WEIGHT: if (issue_last) state_nxt = S_D2;
      S_D2:     if (drain_done) state_nxt = S_OUT;
      S_OUT:    if (out_last) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so that issue and
  // output indices appear in the first cycle of their state.
  always_comb begin
    issue_vld_d = 1'b0;
    phase_d     = 2'd0;
    irow_d      = 3'd0;
    icol_d      = 3'd0;
    ov_d        = 1'b0;
    orow_d      = 3'd0;
    ocol_d      = 3'd0;
    unique case (state_nxt)
      S_PROJ, S_SCORE, S_WEIGHT: begin
        issue_vld_d = 1'b1;
        phase_d     = (state_nxt == S_PROJ) ? 2'd0 : (state_nxt == S_SCORE) ? 2'd1 : 2'd2;
        if (state == state_nxt) begin
          if (icol_q == col_last) begin
            irow_d = irow_q + 3'd1;
            icol_d = 3'd0;
          end else begin
            irow_d = irow_q;
            icol_d = icol_q + 3'd1;
          end
        end
      end
      S_OUT: begin
        ov_d = 1'b1;
        if (state == S_OUT) begin
          if (ocol_q == 3'd7) begin
            orow_d = orow_q + 3'd1;
            ocol_d = 3'd0;
          end else begin
            orow_d = orow_q;
            ocol_d = ocol_q + 3'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Drain timer reloads every cycle outside a drain state and counts down inside.
  assign drain_d = (state == S_D0 || state == S_D1 || state == S_D2) ? drain_q - 1'b1 : DRAIN_INIT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q      <= 6'd0;
      teff_q      <= 4'd1;
      drain_q     <= '0;
      issue_vld_q <= 1'b0;
      phase_q     <= 2'd0;
      irow_q      <= 3'd0;
      icol_q      <= 3'd0;
      ov_q        <= 1'b0;
      orow_q      <= 3'd0;
      ocol_q      <= 3'd0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      if (ld_act && bus.in_valid) beat_q <= beat_q + 6'd1;
      if (state == S_IDLE && bus.in_valid) teff_q <= teff_in;
      drain_q     <= drain_d;
      issue_vld_q <= issue_vld_d;
      phase_q     <= phase_d;
      irow_q      <= irow_d;
      icol_q      <= icol_d;
      ov_q        <= ov_d;
      orow_q      <= orow_d;
      ocol_q      <= ocol_d;
      busy_q      <= (state_nxt != S_IDLE);
      ovr_q       <= bus.in_valid && !ld_act;
    end
  end

  assign bus.ld_addr       = beat_q;
  assign bus.w_we          = ld_act && bus.in_valid;
  assign bus.x_we          = ld_act && bus.in_valid && ({1'b0, beat_q} < {teff_cur, 3'b000});
  assign bus.issue_vld     = issue_vld_q;
  assign bus.issue_phase   = phase_q;
  assign bus.issue_row     = irow_q;
  assign bus.issue_col     = icol_q;
  assign bus.out_valid     = ov_q;
  assign bus.out_row       = orow_q;
  assign bus.out_col       = ocol_q;
  assign bus.busy          = busy_q;
  assign bus.ovr_err       = ovr_q;
  assign bus.gclk_en_ld    = !bus.cg_en || ld_act;
  assign bus.gclk_en_proj  = !bus.cg_en || state == S_PROJ || state == S_D0;
  assign bus.gclk_en_score = !bus.cg_en || state == S_SCORE || state == S_D1;
  assign bus.gclk_en_wt    = !bus.cg_en || state == S_WEIGHT || state == S_D2;
  assign bus.gclk_en_out   = !bus.cg_en || state == S_OUT;

endmodule

// File: tb/tb_sa_sched.sv
// Scoreboard bench for sa_sched: expected issue/output timelines are queued per
// job and compared as the scheduler produces them.
module tb_sa_sched;
  logic clk = 1'b0;
  logic rst;
  sa_sched_if bus();

  sa_sched #(.MAC_LAT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int base    = 0;
  int mon_rel;
  bit mon_en  = 1'b0;
  logic [23:0] iss_q[$];
  logic [23:0] out_q[$];
  logic [23:0] mon_exp;
  logic [4:0]  en_vec;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Entries: {cycle relative to beat 63, phase, row, col}
  task automatic push_job(input int teff);
    int c = 1;
    for (int p = 0; p < 3; p++) begin
      for (int r = 0; r < teff; r++)
        for (int k = 0; k < ((p == 1) ? teff : 8); k++) begin
          iss_q.push_back({16'(c), 2'(p), 3'(r), 3'(k)});
          c++;
        end
      c += 4;
    end
    for (int r = 0; r < teff; r++)
      for (int k = 0; k < 8; k++) begin
        out_q.push_back({16'(c), 2'd0, 3'(r), 3'(k)});
        c++;
      end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      mon_rel = cyc - base;
      if (bus.issue_vld) begin
        mon_exp = (iss_q.size() > 0) ? iss_q.pop_front() : 24'hffffff;
        chk("issue", {mon_rel[15:0], bus.issue_phase, bus.issue_row, bus.issue_col}, mon_exp);
      end
      if (bus.out_valid) begin
        mon_exp = (out_q.size() > 0) ? out_q.pop_front() : 24'hffffff;
        chk("out", {mon_rel[15:0], 2'd0, bus.out_row, bus.out_col}, mon_exp);
      end
      en_vec = {bus.gclk_en_ld, bus.gclk_en_proj, bus.gclk_en_score, bus.gclk_en_wt, bus.gclk_en_out};
      if (bus.cg_en) begin
        chk("cg_onehot", $countones(en_vec), 1);
        if (bus.issue_vld) chk("cg_phase", en_vec, 5'b01000 >> bus.issue_phase);
        if (bus.out_valid) chk("cg_out", en_vec, 5'b00001);
      end else begin
        chk("cg_off", en_vec, 5'h1f);
      end
    end
  end

  // Called and returns at posedge+1; beat 0 is driven in the current cycle.
  task automatic run_job(input int t_in, input int gap_at, input int gap_len,
                         input bit ovr_pulse, input bit abort);
    int teff, stage;
    bit done;
    teff = (t_in == 1) ? 1 : (t_in == 4) ? 4 : 8;
    push_job(teff);
    mon_en = 1'b1;
    for (int b = 0; b < 64; b++) begin
      bus.in_valid = 1'b1;
      bus.T = (b == 0) ? 4'(t_in) : 4'($urandom_range(0, 15));
      if (b == 63) base = cyc;
      @(negedge clk);
      chk("ld_addr", bus.ld_addr, b);
      chk("w_we", bus.w_we, 1);
      chk("x_we", bus.x_we, (b < teff * 8));
      chk("busy_ld", bus.busy, (b != 0));
      chk("iss_ld", bus.issue_vld, 0);
      if (bus.cg_en) chk("en_ld", bus.gclk_en_ld, 1);
      @(posedge clk); #1;
      if (b == gap_at) begin
        bus.in_valid = 1'b0;
        repeat (gap_len) begin
          @(negedge clk);
          chk("gap_we", {bus.w_we, bus.x_we}, 0);
          chk("gap_addr", bus.ld_addr, b + 1);
          @(posedge clk); #1;
        end
      end
    end
    bus.in_valid = 1'b0;
    stage = 0;
    done  = 1'b0;
    for (int budget = 0; budget < 400 && !done; budget++) begin
      @(posedge clk); #1;
      if (abort && bus.issue_vld && bus.issue_phase == 2'd2) begin
        mon_en = 1'b0;
        iss_q.delete();
        out_q.delete();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        chk("abort_iss", bus.issue_vld, 0);
        chk("abort_out", bus.out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (ovr_pulse) begin
        if (stage == 0 && bus.issue_vld && bus.issue_phase == 2'd1) begin
          chk("ovr_pre", bus.ovr_err, 0);
          bus.in_valid = 1'b1;
          stage = 1;
        end else if (stage == 1) begin
          bus.in_valid = 1'b0;
          @(negedge clk);
          chk("ovr_pulse", bus.ovr_err, 1);
          stage = 2;
        end else if (stage == 2) begin
          @(negedge clk);
          chk("ovr_clear", bus.ovr_err, 0);
          stage = 3;
        end
      end
      done = (iss_q.size() == 0) && (out_q.size() == 0);
    end
    chk("job_done", done, 1);
    chk("ovr_stage", stage, ovr_pulse ? 3 : 0);
    chk("end_busy", bus.busy, 0);
    chk("end_out", bus.out_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.T = 4'd0;
    bus.cg_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_iss", {bus.issue_vld, bus.issue_phase, bus.issue_row, bus.issue_col}, 0);
    chk("rst_out", {bus.out_valid, bus.out_row, bus.out_col}, 0);
    chk("rst_ovr", bus.ovr_err, 0);
    chk("rst_ld", {bus.ld_addr, bus.x_we, bus.w_we}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_job(1, -1, 0, 1'b0, 1'b0);
    run_job(8, 20, 3, 1'b0, 1'b0);
    bus.cg_en = 1'b0;
    run_job(5, -1, 0, 1'b0, 1'b0);
    bus.cg_en = 1'b1;
    run_job(4, -1, 0, 1'b1, 1'b0);
    run_job(8, -1, 0, 1'b0, 1'b1);
    run_job(4, -1, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
